// File: rtl/move_profile_ctrl.sv
// Trapezoidal velocity-profile scheduler for one wrapped-encoder axis.
// Produces the sample tick, per-sample v_cmd and the registered velocity error.
module move_profile_ctrl #(
    parameter int CPR       = 1496,
    parameter int TICK_BITS = 17,
    parameter int V_CREEP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        dir_in,
    input  logic [31:0] target,
    input  logic [15:0] v_max,
    input  logic [15:0] accel,
    input  logic [15:0] enc_count,
    input  logic [15:0] meas_vel,
    output logic        sample_tick,
    output logic [15:0] v_cmd,
    output logic        dir,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [16:0] vel_err,
    output logic [31:0] traveled,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_BITS-1:0] div_q, div_d;
    logic [15:0]          v_cmd_q, v_cmd_d;
    logic                 dir_q, dir_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic [16:0]          vel_err_q, vel_err_d;
    logic [31:0]          traveled_q, traveled_d;
    logic [31:0]          target_q, target_d;
    logic [15:0]          v_max_q, v_max_d;
    logic [15:0]          accel_q, accel_d;
    logic [15:0]          prev_pos_q, prev_pos_d;
    logic [31:0]          brake_q, brake_d;

    logic        tick;
    logic [16:0] pos, prv, cpr, delta;
    logic [32:0] trav_sum, brake_sum;
    logic [31:0] trav_n, rem, brake_n;
    logic [16:0] vn_sum, dec_thr;
    logic [15:0] vn;
    logic        params_ok;

    assign tick = &div_q;

    always_comb begin
        pos = {1'b0, enc_count};
        prv = {1'b0, prev_pos_q};
        cpr = 17'(CPR);
        if (dir_q) begin
            delta = (pos >= prv) ? pos - prv : pos + cpr - prv;
        end else begin
            delta = (prv >= pos) ? prv - pos : prv + cpr - pos;
        end
        trav_sum  = {1'b0, traveled_q} + {16'b0, delta};
        trav_n    = trav_sum[32] ? 32'hFFFF_FFFF : trav_sum[31:0];
        rem       = (trav_n >= target_q) ? 32'd0 : target_q - trav_n;
        vn_sum    = {1'b0, v_cmd_q} + {1'b0, accel_q};
        vn        = (vn_sum > {1'b0, v_max_q}) ? v_max_q : vn_sum[15:0];
        brake_sum = {1'b0, brake_q} + {17'b0, vn};
        brake_n   = brake_sum[32] ? 32'hFFFF_FFFF : brake_sum[31:0];
        dec_thr   = {1'b0, accel_q} + 17'(V_CREEP);
        params_ok = (target != 32'd0) && (v_max != 16'd0)
                    && (accel != 16'd0);
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q + 1'b1;
        v_cmd_d    = v_cmd_q;
        dir_d      = dir_q;
        aborted_d  = aborted_q;
        vel_err_d  = vel_err_q;
        traveled_d = traveled_q;
        target_d   = target_q;
        v_max_d    = v_max_q;
        accel_d    = accel_q;
        prev_pos_d = prev_pos_q;
        brake_d    = brake_q;
        done_d     = (state_q == S_DONE);

        if (tick) begin
            vel_err_d = {1'b0, v_cmd_q} - {1'b0, meas_vel};
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && params_ok) begin
                    target_d   = target;
                    v_max_d    = v_max;
                    accel_d    = accel;
                    dir_d      = dir_in;
                    prev_pos_d = enc_count;
                    traveled_d = 32'd0;
                    brake_d    = 32'd0;
                    v_cmd_d    = 16'd0;
                    aborted_d  = 1'b0;
                    state_d    = S_ACCEL;
                end else if (start) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (abort) begin
                    v_cmd_d   = 16'd0;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (tick) begin
                    prev_pos_d = enc_count;
                    traveled_d = trav_n;
                    if (rem == 32'd0) begin
                        v_cmd_d = 16'd0;
                        state_d = S_DONE;
                    end else if (state_q == S_ACCEL) begin
                        brake_d = brake_n;
                        v_cmd_d = vn;
                        if ({1'b0, rem} <= brake_sum) begin
                            state_d = S_DECEL;
                        end else if (vn == v_max_q) begin
                            state_d = S_CRUISE;
                        end
                    end else if (state_q == S_CRUISE) begin
                        if (rem <= brake_q) begin
                            state_d = S_DECEL;
                        end
                    end else begin
                        // Hold a creep speed so the target is always reached
                        v_cmd_d = ({1'b0, v_cmd_q} > dec_thr)
                                  ? v_cmd_q - accel_q : 16'(V_CREEP);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ACCEL) || (state_d == S_CRUISE)
                 || (state_d == S_DECEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            v_cmd_q    <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            vel_err_q  <= '0;
            traveled_q <= '0;
            target_q   <= '0;
            v_max_q    <= '0;
            accel_q    <= '0;
            prev_pos_q <= '0;
            brake_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            v_cmd_q    <= v_cmd_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            vel_err_q  <= vel_err_d;
            traveled_q <= traveled_d;
            target_q   <= target_d;
            v_max_q    <= v_max_d;
            accel_q    <= accel_d;
            prev_pos_q <= prev_pos_d;
            brake_q    <= brake_d;
        end
    end

    assign sample_tick = tick;
    assign v_cmd       = v_cmd_q;
    assign dir         = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign vel_err     = vel_err_q;
    assign traveled    = traveled_q;
    assign state       = state_q;

endmodule
